// File: rtl/hash_nonce_sched_pkg.sv
// Shared constants for the nonce-sweep scheduler and the 3-byte micro hash core.
package hash_pkg;
    localparam int HASH_W        = 24;
    localparam int BLOCK_W       = 128;
    localparam int HDR_BYTES_DEF = 12;

    localparam logic [7:0] H0_INIT = 8'h01;
    localparam logic [7:0] H1_INIT = 8'h89;
    localparam logic [7:0] H2_INIT = 8'hfe;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LOAD  = 2'd1;
    localparam state_t RUN   = 2'd2;
    localparam state_t CHECK = 2'd3;

    // H2 is deliberately left out of the difficulty test.
    function automatic logic is_hit(input logic [HASH_W-1:0] h, input logic [7:0] tgt);
        return (h[23:16] < tgt) && (h[15:8] < tgt);
    endfunction
endpackage

// File: rtl/hash_nonce_cnt.sv
// Loadable nonce counter with modular increment and a registered "at last nonce" flag.
module hash_nonce_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] first,
    input  logic [W-1:0] last,
    output logic [W-1:0] nonce,
    output logic         at_last
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] last_q;
    logic [W-1:0] nonce_inc;

    assign nonce_inc = nonce + ONE;

    // at_last tracks the value being written so it is ready when CHECK looks at it.
    always_ff @(posedge clk) begin
        if (reset) begin
            nonce   <= '0;
            last_q  <= '0;
            at_last <= 1'b0;
        end else if (load) begin
            nonce   <= first;
            last_q  <= last;
            at_last <= (first == last);
        end else if (inc) begin
            nonce   <= nonce_inc;
            at_last <= (nonce_inc == last_q);
        end
    end
endmodule

// File: rtl/hash_nonce_sched.sv
// Nonce-sweep scheduler driving one micro hash core.
// Optional core watchdog enabled by defining HASH_WDOG_EN (adds wdog_err port).
module hash_nonce_sched
    import hash_pkg::*;
#(
    parameter int NONCE_W   = 32,
    parameter int HDR_BYTES = HDR_BYTES_DEF,
    parameter int WDOG_CYC  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [8*HDR_BYTES-1:0] header,
    input  logic [7:0]             target,
    input  logic [NONCE_W-1:0]     nonce_first,
    input  logic [NONCE_W-1:0]     nonce_last,
    output logic [BLOCK_W-1:0]     core_block,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [HASH_W-1:0]      core_hash,
    output logic                   busy,
    output logic                   found,
    output logic                   exhausted,
    output logic [NONCE_W-1:0]     found_nonce,
    output logic [HASH_W-1:0]      found_hash,
`ifdef HASH_WDOG_EN
    output logic                   wdog_err,
`endif
    output logic [NONCE_W-1:0]     attempts
);
    localparam logic [NONCE_W-1:0] ONE = NONCE_W'(1);

    state_t                 state;
    logic [8*HDR_BYTES-1:0] hdr_q;
    logic [7:0]             target_q;
    logic [HASH_W-1:0]      hash_q;
    logic [NONCE_W-1:0]     cur_nonce;
    logic                   at_last;
    logic                   hit;
    logic                   accept;
    logic                   cnt_inc;

    assign hit        = is_hit(hash_q, target_q);
    assign accept     = (state == IDLE) && start && !abort;
    assign cnt_inc    = (state == CHECK) && !hit && !at_last && !abort;
    assign busy       = (state != IDLE);
    assign core_start = (state == LOAD) && !abort;
    // Nonce only moves on CHECK->LOAD, so the block is stable across LOAD..CHECK.
    assign core_block = {cur_nonce, hdr_q};

    hash_nonce_cnt #(.W(NONCE_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .inc     (cnt_inc),
        .first   (nonce_first),
        .last    (nonce_last),
        .nonce   (cur_nonce),
        .at_last (at_last)
    );

`ifdef HASH_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hdr_q       <= '0;
            target_q    <= '0;
            hash_q      <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            attempts    <= '0;
`ifdef HASH_WDOG_EN
            wdog_cnt    <= '0;
            wdog_err    <= 1'b0;
`endif
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    hdr_q       <= header;
                    target_q    <= target;
                    found       <= 1'b0;
                    exhausted   <= 1'b0;
                    found_nonce <= '0;
                    found_hash  <= '0;
                    attempts    <= '0;
`ifdef HASH_WDOG_EN
                    wdog_err    <= 1'b0;
`endif
                    state       <= LOAD;
                end
                LOAD: begin
`ifdef HASH_WDOG_EN
                    wdog_cnt <= '0;
`endif
                    state    <= RUN;
                end
                RUN: if (core_done) begin
                    hash_q <= core_hash;
                    if (attempts != '1) attempts <= attempts + ONE;
                    state  <= CHECK;
                end
`ifdef HASH_WDOG_EN
                else if (wdog_cnt == WD_W'(WDOG_CYC - 1)) begin
                    wdog_err <= 1'b1;
                    state    <= IDLE;
                end else begin
                    wdog_cnt <= wdog_cnt + WD_W'(1);
                end
`endif
                CHECK: begin
                    if (hit) begin
                        found       <= 1'b1;
                        found_nonce <= cur_nonce;
                        found_hash  <= hash_q;
                        state       <= IDLE;
                    end else if (at_last) begin
                        exhausted <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/hash_nonce_sched.md
Name: hash_nonce_sched

Overview:
Nonce-sweep scheduler for the 3-byte micro hash core. Latches a 12-byte header, target and nonce range from the host. Repeatedly loads the core with header plus nonce and starts one hash. Compares each digest against the target, stops on the first qualifying nonce or when the range is exhausted. Sits between the host register interface and a single hash core instance.

Parameters:
NONCE_W, 32, nonce width in bits; bytes 12..15 of the core block
HDR_BYTES, 12, header bytes forwarded unchanged into core block bytes 0..11
WDOG_CYC, 64, max cycles to wait for core_done (used only with HASH_WDOG_EN)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; ignored while busy=1
abort  in  1  level; forces return to IDLE
header  in  8*HDR_BYTES  header, latched on accepted start
target  in  8  difficulty threshold, latched on accepted start
nonce_first  in  NONCE_W  first nonce, latched on accepted start
nonce_last  in  NONCE_W  last nonce (inclusive), latched on accepted start
core_block  out  128  {nonce, header}; byte i = bits [8i+7:8i], nonce little-endian in bytes 12..15
core_start  out  1  one-cycle pulse, block valid in the same cycle
core_done  in  1  one-cycle pulse, digest valid in the same cycle
core_hash  in  24  digest {H0,H1,H2}, H0 = bits [23:16]
busy  out  1  high in every state except IDLE
found  out  1  sticky; set when a qualifying nonce is seen
exhausted  out  1  sticky; set when the range ends without a hit
found_nonce  out  NONCE_W  nonce that qualified
found_hash  out  24  digest that qualified
attempts  out  NONCE_W  hashes completed in the current sweep

Behaviour:
- Reset: state=IDLE; all outputs 0; core_block=0; latched registers 0.
- IDLE: on start=1, latch header, target, nonce_first, nonce_last. Set cur_nonce=nonce_first. Clear found, exhausted, found_nonce, found_hash and attempts. Go to LOAD.
- LOAD (1 cycle): core_block driven from latches; core_start=1; go to RUN. core_block holds stable from LOAD until the state leaves CHECK.
- RUN: wait for core_done. On core_done, register core_hash, increment attempts, go to CHECK.
- CHECK (1 cycle): a hit is (H0 < target) AND (H1 < target), unsigned strict compare; H2 is not compared.
  - Hit: found=1, found_nonce=cur_nonce, found_hash=digest; go to IDLE.
  - Miss and cur_nonce==nonce_last: exhausted=1; go to IDLE.
  - Otherwise: cur_nonce+1 (mod 2^NONCE_W); go to LOAD.
- Latency per attempt: 2 cycles + core latency (LOAD, RUN..done, CHECK).
- Range wrap: if nonce_last < nonce_first, the sweep wraps through all-ones to 0 and ends at nonce_last. If nonce_first==nonce_last, exactly one attempt is made.
- core_done outside RUN is ignored. core_done in the same cycle as core_start is not possible; the core takes at least 1 cycle.
- abort has priority over everything. Next state is IDLE, core_start is 0, and found/exhausted are not set. Result registers and attempts keep their values. start arriving in the same cycle as abort is dropped.
- reset mid-sweep: all state returns to reset values on the next edge, regardless of pending core_done.
- attempts saturates at all-ones and does not wrap.

Optional Feature:
HASH_WDOG_EN:
- Defined: a counter runs in RUN. If WDOG_CYC cycles pass without core_done, the sweep goes to IDLE and an extra output port wdog_err (1 bit, sticky, cleared on accepted start) is set. found and exhausted are not set in this case.
- Not defined: RUN waits indefinitely, and the wdog_err port does not exist.

Decomposition:
- Package hash_pkg:
  - state enum {IDLE, LOAD, RUN, CHECK}
  - HASH_W=24, BLOCK_W=128, HDR_BYTES default
  - core initial constants H0=8'h01, H1=8'h89, H2=8'hfe, shared with the core
- One sub-module, hash_nonce_cnt: loadable nonce counter with increment, modular wrap and a registered "at last" compare against nonce_last. The scheduler FSM instantiates it.

Test Plan:
- Single-nonce hit: target=8'h80, nonce_first=nonce_last=5, core model returns 24'h10_20_FF → found=1, found_nonce=5, found_hash=24'h1020FF, attempts=1, exhausted=0.
- Range miss: nonce 0..3, core always returns 24'h90_00_00 with target=8'h80 → 4 core_start pulses carrying nonces 0,1,2,3; exhausted=1, found=0, attempts=4.
- Boundary compare: H0=8'h7F, H1=8'h80, target=8'h80 → no hit. Next nonce returns H0=H1=8'h7F → hit on the second attempt.
- Wrap sweep: nonce_first=32'hFFFF_FFFE, nonce_last=1, no hits → nonces FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, attempts=4.
- Abort and reset mid-RUN: abort during the 2nd RUN → IDLE next cycle, busy=0, found=exhausted=0, attempts=1, the late core_done is ignored. Repeat with reset=1 → all outputs 0.
- start while busy is ignored, with no relatch of target. With HASH_WDOG_EN and WDOG_CYC=8, a core that never responds → wdog_err=1 at cycle 8 of RUN, busy=0.
